hazard_detect_unit: RTL and testbench
=====================================

# hazard_detect_unit

Pipeline hazard detector for the five-stage MIPS datapath. It sits between the IF/ID register and the decode controller. It watches the instruction in ID against the ID/EX and EX/MEM stages and produces `hazardjump`, which the controller uses to squash ID controls into a bubble. It also drives the PC-write, IF/ID-write and IF/ID-flush enables for load-use stalls, `jr` operand stalls, jump redirects and taken-branch flushes.

## Interface
- `CNT_W`, default 16: width of the hazard statistics counters.
- `clk  in  1`: pipeline clock; rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `id_opcode  in  6`: opcode of the instruction in ID.
- `id_funct  in  6`: funct field of the instruction in ID.
- `id_rs  in  5`: rs field of the instruction in ID.
- `id_rt  in  5`: rt field of the instruction in ID.
- `idex_memread  in  1`: the instruction in EX is a load.
- `idex_regwrite  in  1`: the instruction in EX writes a register.
- `idex_dst  in  5`: destination register of the instruction in EX.
- `exmem_memread  in  1`: the instruction in MEM is a load.
- `exmem_dst  in  5`: destination register of the instruction in MEM.
- `branch_taken_ex  in  1`: a branch in EX resolved as taken this cycle.
- `pc_write  out  1`: PC update enable.
- `ifid_write  out  1`: IF/ID register load enable.
- `ifid_flush  out  1`: clears IF/ID to a nop on the next edge.
- `hazardjump  out  3`: controller squash code. 0 = pass; 1 = squash (bubble into ID/EX). Values 2–7 are never driven.
- `stall_count  out  CNT_W`: number of stall cycles; present only with `HAZARD_STATS_EN`.
- `flush_count  out  CNT_W`: number of flush events; present only with `HAZARD_STATS_EN`.

## Operation
- **Source-operand usage**
  - `uses_rs`: every instruction except `j` and `jal`.
  - `uses_rt`: R-format (opcode 0), `mul` (011100), `beq`, `bne`, `sw`, `sb`, `sh`.
  - A register match against `$0` never counts as a hazard.
- **Hazard conditions, highest priority first**
  - **Taken branch**: `branch_taken_ex=1`. Drive `ifid_flush=1` and `hazardjump=1`; PC is written with the branch target.
  - **Load-use**: `idex_memread`, and `idex_dst` matches a used rs/rt. Drive `pc_write=0`, `ifid_write=0`, `hazardjump=1`.
  - **jr stall**: opcode 0 with funct 001000.
    - If `idex_regwrite` and `idex_dst==id_rs`: stall as for load-use.
    - If additionally `idex_memread`: the stall is two cycles.
    - If `exmem_memread` and `exmem_dst==id_rs`: stall one cycle.
  - **Jump**: `j` (000010), `jal` (000011), or an unstalled `jr`. Drive `ifid_flush=1` so the fall-through fetch is killed. `hazardjump` stays 0 so the jump's own controls proceed.
- **FSM states**
  - RUN: default state.
  - JR_WAIT: entered from RUN when a `jr` depends on a load in EX. Holds a second stall cycle: `pc_write=0`, `ifid_write=0`, `hazardjump=1`. Always returns to RUN after one cycle.
  - In JR_WAIT a `branch_taken_ex` overrides the stall: flush, then return to RUN.
- Outputs are combinational from state and inputs. The only registered elements are the state and the counters.
- When idle: `pc_write=1`, `ifid_write=1`, `ifid_flush=0`, `hazardjump=0`.

## Timing
- Detection latency is zero: a hazard present in cycle t gates the edge at the end of cycle t.
- A load-use stall lasts exactly 1 cycle. In the next cycle ID/EX holds the bubble, so the hazard clears without any extra state.
- A `jr` after a load in EX stalls exactly 2 cycles. A `jr` after a load in MEM, or after an ALU result in EX, stalls 1 cycle.
- A jump or taken-branch flush costs 1 cycle.
- Reset, asserted asynchronously at any time, including mid-JR_WAIT:
  - State goes to RUN and counters clear to 0.
  - While reset is high, outputs are forced to the idle values: `pc_write=1`, `ifid_write=1`, `ifid_flush=0`, `hazardjump=0`.
- A stall and a taken branch in the same cycle resolve as flush only; that cycle is not counted as a stall.

## Configuration
- `HAZARD_STATS_EN` defined:
  - `stall_count` increments on every cycle with `pc_write=0`.
  - `flush_count` increments on every cycle with `ifid_flush=1`.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: the counter ports and logic are absent. Hazard behaviour is identical.

## Structure
- `hazard_pkg` holds:
  - Opcode and funct constants: OP_RTYPE, OP_MUL, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_SW, OP_SB, OP_SH, FN_JR.
  - HJ_NONE=3'd0 and HJ_SQUASH=3'd1.
  - The state encoding: RUN, JR_WAIT.
- One sub-module, `sat_counter`: parameterised width, enable input, saturating, async reset. It is instantiated twice, only under `HAZARD_STATS_EN`.

## Test plan
- `lw $8,0($9)` in EX (`idex_memread=1`, `idex_dst=8`), `add $10,$8,$11` in ID -> one cycle of `pc_write=0`, `ifid_write=0`, `hazardjump=1`; then all idle values.
- `lw` dst=31 in EX, `jr $31` in ID -> two stall cycles, state passes through JR_WAIT; on cycle 3 `ifid_flush=1`, `hazardjump=0`.
- `j 0x40` in ID, no hazards -> `ifid_flush=1`, `hazardjump=0`, `pc_write=1` for one cycle.
- Load-use and `branch_taken_ex=1` in the same cycle -> `ifid_flush=1`, `hazardjump=1`, `pc_write=1`; `stall_count` unchanged and `flush_count`+1.
- `lw` in EX with `idex_dst=0`, ID reads `$0` -> no stall.
- `reset` pulsed high during JR_WAIT -> outputs return to idle immediately, counters=0, and the next cycle is in RUN.

Source files
------------

// File: rtl/hazard_detect_unit_pkg.sv
// Shared opcode/funct constants, squash codes and FSM state encoding for the hazard detector.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] HJ_NONE   = 3'd0;
    localparam logic [2:0] HJ_SQUASH = 3'd1;

    typedef enum logic {
        RUN     = 1'b0,
        JR_WAIT = 1'b1
    } hd_state_e;

    // rt is a real source only for formats that read it; immediates reuse the field as a destination.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_MUL) || (op == OP_BEQ) || (op == OP_BNE) ||
               (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
    endfunction

endpackage

// File: rtl/hazard_detect_unit_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_detect_unit.sv
// ID-stage hazard detector: load-use and jr stalls, jump/branch flushes.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module hazard_detect_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] id_opcode,
    input  logic [5:0] id_funct,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       idex_memread,
    input  logic       idex_regwrite,
    input  logic [4:0] idex_dst,
    input  logic       exmem_memread,
    input  logic [4:0] exmem_dst,
    input  logic       branch_taken_ex,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       ifid_flush,
    output logic [2:0] hazardjump
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
`endif
);

    hd_state_e state_q;
    hd_state_e state_d;

    logic is_j;
    logic is_jr;
    logic uses_rs;
    logic uses_rt;
    logic rs_live;
    logic rt_live;
    logic load_use;
    logic jr_ex;
    logic jr_mem;
    logic jr_load_ex;

    assign is_j    = (id_opcode == OP_J) || (id_opcode == OP_JAL);
    assign is_jr   = (id_opcode == OP_RTYPE) && (id_funct == FN_JR);
    assign uses_rs = !is_j;
    assign uses_rt = op_uses_rt(id_opcode);

    // $0 is hardwired, so a match on it can never carry a stale value.
    assign rs_live = uses_rs && (id_rs != 5'd0);
    assign rt_live = uses_rt && (id_rt != 5'd0);

    assign load_use   = idex_memread && ((rs_live && (id_rs == idex_dst)) ||
                                         (rt_live && (id_rt == idex_dst)));
    assign jr_ex      = is_jr && rs_live && idex_regwrite && (idex_dst == id_rs);
    assign jr_mem     = is_jr && rs_live && exmem_memread && (exmem_dst == id_rs);
    assign jr_load_ex = jr_ex && idex_memread;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        hazardjump = HJ_NONE;
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (branch_taken_ex) begin
                        ifid_flush = 1'b1;
                        hazardjump = HJ_SQUASH;
                    end else if (load_use || jr_ex || jr_mem) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        hazardjump = HJ_SQUASH;
                        if (jr_load_ex) begin
                            state_d = JR_WAIT;
                        end
                    end else if (is_j || is_jr) begin
                        ifid_flush = 1'b1;
                    end
                end
                JR_WAIT: begin
                    state_d = RUN;
                    if (branch_taken_ex) begin
                        ifid_flush = 1'b1;
                        hazardjump = HJ_SQUASH;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        hazardjump = HJ_SQUASH;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef HAZARD_STATS_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (!pc_write),
        .count_o (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (ifid_flush),
        .count_o (flush_count)
    );
`endif

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed pipeline scenarios then random traffic
// checked against a rule-level model with a pending-extra-stall counter.
module tb_hazard_detect_unit;

    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] id_opcode = '0;
    logic [5:0] id_funct = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic       idex_memread = 1'b0;
    logic       idex_regwrite = 1'b0;
    logic [4:0] idex_dst = '0;
    logic       exmem_memread = 1'b0;
    logic [4:0] exmem_dst = '0;
    logic       branch_taken_ex = 1'b0;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic [2:0] hazardjump;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
`endif

    hazard_detect_unit #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_opcode       (id_opcode),
        .id_funct        (id_funct),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .idex_memread    (idex_memread),
        .idex_regwrite   (idex_regwrite),
        .idex_dst        (idex_dst),
        .exmem_memread   (exmem_memread),
        .exmem_dst       (exmem_dst),
        .branch_taken_ex (branch_taken_ex),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .hazardjump      (hazardjump)
`ifdef HAZARD_STATS_EN
        ,
        .stall_count     (stall_count),
        .flush_count     (flush_count)
`endif
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nFail = 0;

    int         pendingStall = 0;
    int         stallCnt = 0;
    int         flushCnt = 0;
    logic       expPc;
    logic       expIfw;
    logic       expFlush;
    logic [2:0] expHj;
    logic       expJrLoad;

    logic [5:0] opTab [0:10];

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic exMr, input logic exRw, input logic [4:0] exDst,
                                 input logic memMr, input logic [4:0] memDst, input logic br);
        id_opcode       = op;
        id_funct        = fn;
        id_rs           = rs;
        id_rt           = rt;
        idex_memread    = exMr;
        idex_regwrite   = exRw;
        idex_dst        = exDst;
        exmem_memread   = memMr;
        exmem_dst       = memDst;
        branch_taken_ex = br;
    endtask

    // Expected outputs straight from the hazard rules; pendingStall is the owed second jr stall cycle.
    task automatic computeExpected();
        logic isJ, isJr, usesRt, ldUse, jrAlu, jrMem;
        isJ    = (id_opcode == 6'd2) || (id_opcode == 6'd3);
        isJr   = (id_opcode == 6'd0) && (id_funct == 6'd8);
        usesRt = (id_opcode == 6'h00) || (id_opcode == 6'h1c) || (id_opcode == 6'h04) ||
                 (id_opcode == 6'h05) || (id_opcode == 6'h2b) || (id_opcode == 6'h28) ||
                 (id_opcode == 6'h29);
        ldUse  = idex_memread && ((!isJ && id_rs != 0 && id_rs == idex_dst) ||
                                  (usesRt && id_rt != 0 && id_rt == idex_dst));
        jrAlu  = isJr && id_rs != 0 && idex_regwrite && idex_dst == id_rs;
        jrMem  = isJr && id_rs != 0 && exmem_memread && exmem_dst == id_rs;
        expJrLoad = jrAlu && idex_memread;
        expPc = 1'b1; expIfw = 1'b1; expFlush = 1'b0; expHj = 3'd0;
        if (reset) begin
            expJrLoad = 1'b0;
        end else if (branch_taken_ex) begin
            expFlush = 1'b1; expHj = 3'd1;
        end else if (pendingStall > 0 || ldUse || jrAlu || jrMem) begin
            expPc = 1'b0; expIfw = 1'b0; expHj = 3'd1;
        end else if (isJ || isJr) begin
            expFlush = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        nVec++;
        assert (pc_write === expPc) else begin
            nFail++;
            $error("FAIL %s pc_write: observed %0b expected %0b", tag, pc_write, expPc);
        end
        nVec++;
        assert (ifid_write === expIfw) else begin
            nFail++;
            $error("FAIL %s ifid_write: observed %0b expected %0b", tag, ifid_write, expIfw);
        end
        nVec++;
        assert (ifid_flush === expFlush) else begin
            nFail++;
            $error("FAIL %s ifid_flush: observed %0b expected %0b", tag, ifid_flush, expFlush);
        end
        nVec++;
        assert (hazardjump === expHj) else begin
            nFail++;
            $error("FAIL %s hazardjump: observed %0d expected %0d", tag, hazardjump, expHj);
        end
`ifdef HAZARD_STATS_EN
        nVec++;
        assert (stall_count === CNT_W'(stallCnt)) else begin
            nFail++;
            $error("FAIL %s stall_count: observed %0d expected %0d", tag, stall_count, stallCnt);
        end
        nVec++;
        assert (flush_count === CNT_W'(flushCnt)) else begin
            nFail++;
            $error("FAIL %s flush_count: observed %0d expected %0d", tag, flush_count, flushCnt);
        end
`endif
    endtask

    // Called one timestep after a rising edge with inputs already applied; returns likewise.
    task automatic stepCycle(input string tag);
        #2;
        computeExpected();
        checkOutput(tag);
        @(posedge clk);
        if (reset) begin
            pendingStall = 0; stallCnt = 0; flushCnt = 0;
        end else begin
            if (!expPc && stallCnt < CNT_MAX) stallCnt++;
            if (expFlush && flushCnt < CNT_MAX) flushCnt++;
            if (pendingStall > 0) pendingStall = 0;
            else if (!branch_taken_ex && expJrLoad) pendingStall = 1;
        end
        #1;
    endtask

    initial begin
        opTab[0] = 6'h00; opTab[1] = 6'h00; opTab[2] = 6'h1c; opTab[3] = 6'h02;
        opTab[4] = 6'h03; opTab[5] = 6'h04; opTab[6] = 6'h05; opTab[7] = 6'h2b;
        opTab[8] = 6'h28; opTab[9] = 6'h29; opTab[10] = 6'h23;

        // Reset held: idle outputs, then release.
        @(posedge clk); #1;
        applyStimulus(6'h00, 6'h20, 5'd8, 5'd8, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        stepCycle("reset_idle");
        reset = 1'b0;

        // lw $8 in EX, add $10,$8,$11 in ID: one stall, then bubble clears it.
        applyStimulus(6'h00, 6'h20, 5'd8, 5'd11, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
        stepCycle("loaduse_stall");
        applyStimulus(6'h00, 6'h20, 5'd8, 5'd11, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
        stepCycle("loaduse_clear");

        // lw $31 in EX, jr $31: two stalls then the jr's own flush.
        applyStimulus(6'h00, 6'h08, 5'd31, 5'd0, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        stepCycle("jr_stall1");
        applyStimulus(6'h00, 6'h08, 5'd31, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0);
        stepCycle("jr_stall2");
        applyStimulus(6'h00, 6'h08, 5'd31, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        stepCycle("jr_go");

        // ALU result feeding jr: single stall.
        applyStimulus(6'h00, 6'h08, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
        stepCycle("jr_alu_stall");
        applyStimulus(6'h00, 6'h08, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        stepCycle("jr_alu_go");

        // j 0x40 with no hazards.
        applyStimulus(6'h02, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        stepCycle("jump_flush");

        // Load-use coincident with a taken branch: flush only.
        applyStimulus(6'h00, 6'h20, 5'd8, 5'd11, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1);
        stepCycle("branch_over_stall");

        // Load into $0 never stalls a reader of $0.
        applyStimulus(6'h00, 6'h20, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        stepCycle("zero_reg");

        // Branch taken while in JR_WAIT overrides the second stall.
        applyStimulus(6'h00, 6'h08, 5'd31, 5'd0, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        stepCycle("jrw_enter");
        applyStimulus(6'h00, 6'h08, 5'd31, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        stepCycle("jrw_branch");

        // Reset asserted mid-JR_WAIT: idle immediately, RUN afterwards.
        applyStimulus(6'h00, 6'h08, 5'd31, 5'd0, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
        stepCycle("rst_enter");
        applyStimulus(6'h00, 6'h20, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        reset = 1'b1;
        stepCycle("rst_hold");
        reset = 1'b0;
        stepCycle("rst_run");

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = opTab[$urandom_range(0, 10)];
            applyStimulus(op, ($urandom_range(0, 1) == 1) ? 6'h08 : 6'h20,
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
            stepCycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
